tlb_lookup_ctrl: RTL and testbench

Lookup/fill controller that sits directly upstream of the set-associative TLB storage array. It accepts one translation request at a time, reads one set, and compares VPN tags across all ways. On a hit it bumps that way's LRU counter. On a miss it issues a page-table-walk request and writes the returned entry into a victim way. It returns the physical address, or a fault, to the requester over a valid/ready handshake.

---
 rtl/tlb_lookup_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_tlb_lookup_ctrl.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_ctrl.sv
// TLB lookup/fill controller: one request at a time, set read,
// tag compare, LRU bump on hit, page walk and victim fill on miss.
module tlb_lookup_ctrl #(
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_vaddr,
    input  logic                         req_is_write,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [31:0]                  resp_paddr,
    output logic                         resp_hit,
    output logic                         resp_fault,
    output logic                         ptw_req_valid,
    input  logic                         ptw_req_ready,
    output logic [19:0]                  ptw_vpn,
    input  logic                         ptw_resp_valid,
    input  logic [19:0]                  ptw_resp_ppn,
    input  logic [1:0]                   ptw_resp_perms,
    input  logic                         ptw_resp_fault,
    output logic [SET_INDEX_BITS-1:0]    st_rd_set_index,
    input  logic [NUM_WAYS-1:0]          st_rd_valid,
    input  logic [NUM_WAYS*20-1:0]       st_rd_vpn,
    input  logic [NUM_WAYS*20-1:0]       st_rd_ppn,
    input  logic [NUM_WAYS*2-1:0]        st_rd_perms,
    input  logic [NUM_WAYS*LRU_BITS-1:0] st_rd_lru_count,
    output logic                         st_wr_en,
    output logic                         st_update_en,
    output logic [SET_INDEX_BITS-1:0]    st_wr_set_index,
    output logic [1:0]                   st_wr_way,
    output logic                         st_wr_valid,
    output logic [19:0]                  st_wr_vpn,
    output logic [19:0]                  st_wr_ppn,
    output logic [1:0]                   st_wr_perms,
    output logic [LRU_BITS-1:0]          st_wr_lru_count,
    output logic                         st_lru_update_en,
    output logic [SET_INDEX_BITS-1:0]    st_lru_set_index,
    output logic [1:0]                   st_lru_way
);

    localparam int VPN_W = 20;

    if (NUM_SETS != (1 << SET_INDEX_BITS)) begin : g_bad_sets
        $error("NUM_SETS must equal 2**SET_INDEX_BITS");
    end

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WALK_REQ, WALK_WAIT, FILL, RESP
    } state_t;

    state_t      state;
    logic [19:0] vpn_q;
    logic [11:0] off_q;
    logic        wr_q;
    logic [1:0]  victim_q;
    logic [19:0] ppn_q;
    logic [1:0]  perms_q;

    logic                hit;
    logic [1:0]          hit_way;
    logic [19:0]         hit_ppn;
    logic [1:0]          hit_perms;
    logic [LRU_BITS-1:0] hit_lru;
    logic                hit_fault;
    logic                fill_fault;
    logic                inv_found;
    logic [1:0]          inv_way;
    logic [1:0]          min_way;
    logic [LRU_BITS-1:0] min_lru;
    logic [1:0]          victim;
    logic [SET_INDEX_BITS-1:0] set_idx;

    assign set_idx         = vpn_q[SET_INDEX_BITS-1:0];
    assign st_rd_set_index = set_idx;
    assign st_wr_lru_count = '0;

    // Tag compare across ways and victim selection for the current set
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        min_way   = '0;
        min_lru   = st_rd_lru_count[LRU_BITS-1:0];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && st_rd_valid[w] &&
                st_rd_vpn[w*VPN_W +: VPN_W] == vpn_q) begin
                hit     = 1'b1;
                hit_way = w[1:0];
            end
            if (!inv_found && !st_rd_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = w[1:0];
            end
            if (st_rd_lru_count[w*LRU_BITS +: LRU_BITS] < min_lru) begin
                min_lru = st_rd_lru_count[w*LRU_BITS +: LRU_BITS];
                min_way = w[1:0];
            end
        end
        victim    = inv_found ? inv_way : min_way;
        hit_ppn   = st_rd_ppn[int'(hit_way)*VPN_W +: VPN_W];
        hit_perms = st_rd_perms[int'(hit_way)*2 +: 2];
        hit_lru   = st_rd_lru_count[int'(hit_way)*LRU_BITS +: LRU_BITS];
        hit_fault  = wr_q ? !hit_perms[1] : !hit_perms[0];
        fill_fault = wr_q ? !perms_q[1] : !perms_q[0];
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vpn_q            <= '0;
            off_q            <= '0;
            wr_q             <= 1'b0;
            victim_q         <= '0;
            ppn_q            <= '0;
            perms_q          <= '0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_paddr       <= '0;
            resp_hit         <= 1'b0;
            resp_fault       <= 1'b0;
            ptw_req_valid    <= 1'b0;
            ptw_vpn          <= '0;
            st_wr_en         <= 1'b0;
            st_update_en     <= 1'b0;
            st_wr_set_index  <= '0;
            st_wr_way        <= '0;
            st_wr_valid      <= 1'b0;
            st_wr_vpn        <= '0;
            st_wr_ppn        <= '0;
            st_wr_perms      <= '0;
            st_lru_update_en <= 1'b0;
            st_lru_set_index <= '0;
            st_lru_way       <= '0;
        end else begin
            st_wr_en         <= 1'b0;
            st_update_en     <= 1'b0;
            st_wr_valid      <= 1'b0;
            st_lru_update_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        vpn_q     <= req_vaddr[31:12];
                        off_q     <= req_vaddr[11:0];
                        wr_q      <= req_is_write;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_fault <= hit_fault;
                        resp_paddr <= hit_fault ? 32'h0 : {hit_ppn, off_q};
                        if (hit_lru != '1) begin
                            st_wr_en         <= 1'b1;
                            st_lru_update_en <= 1'b1;
                            st_lru_set_index <= set_idx;
                            st_lru_way       <= hit_way;
                        end
                        state <= RESP;
                    end else begin
                        victim_q      <= victim;
                        ptw_req_valid <= 1'b1;
                        ptw_vpn       <= vpn_q;
                        state         <= WALK_REQ;
                    end
                end
                WALK_REQ: begin
                    if (ptw_req_ready) begin
                        ptw_req_valid <= 1'b0;
                        state         <= WALK_WAIT;
                    end
                end
                WALK_WAIT: begin
                    if (ptw_resp_valid) begin
                        if (ptw_resp_fault) begin
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_fault <= 1'b1;
                            resp_paddr <= 32'h0;
                            state      <= RESP;
                        end else begin
                            ppn_q           <= ptw_resp_ppn;
                            perms_q         <= ptw_resp_perms;
                            st_wr_en        <= 1'b1;
                            st_update_en    <= 1'b1;
                            st_wr_set_index <= set_idx;
                            st_wr_way       <= victim_q;
                            st_wr_valid     <= 1'b1;
                            st_wr_vpn       <= vpn_q;
                            st_wr_ppn       <= ptw_resp_ppn;
                            st_wr_perms     <= ptw_resp_perms;
                            state           <= FILL;
                        end
                    end
                end
                FILL: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_fault <= fill_fault;
                    resp_paddr <= fill_fault ? 32'h0 : {ppn_q, off_q};
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_paddr <= '0;
                        resp_hit   <= 1'b0;
                        resp_fault <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Bench for tlb_lookup_ctrl: storage fixture, transaction-level TLB
// reference model, per-cycle compare process and directed scenarios.
module tb_tlb_lookup_ctrl;

    localparam int NS = 16;
    localparam int NW = 4;
    localparam int SB = 4;
    localparam int LB = 4;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_is_write;
    logic [31:0] req_vaddr;
    logic resp_valid, resp_ready, resp_hit, resp_fault;
    logic [31:0] resp_paddr;
    logic ptw_req_valid, ptw_req_ready, ptw_resp_valid, ptw_resp_fault;
    logic [19:0] ptw_vpn, ptw_resp_ppn;
    logic [1:0] ptw_resp_perms;
    logic [SB-1:0] st_rd_set_index, st_wr_set_index, st_lru_set_index;
    logic [NW-1:0] st_rd_valid;
    logic [NW*20-1:0] st_rd_vpn, st_rd_ppn;
    logic [NW*2-1:0] st_rd_perms;
    logic [NW*LB-1:0] st_rd_lru_count;
    logic st_wr_en, st_update_en, st_wr_valid, st_lru_update_en;
    logic [1:0] st_wr_way, st_wr_perms, st_lru_way;
    logic [19:0] st_wr_vpn, st_wr_ppn;
    logic [LB-1:0] st_wr_lru_count;

    always #5 clk = ~clk;

    tlb_lookup_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW),
                      .SET_INDEX_BITS(SB), .LRU_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_is_write(req_is_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_paddr(resp_paddr), .resp_hit(resp_hit),
        .resp_fault(resp_fault),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_vpn(ptw_vpn), .ptw_resp_valid(ptw_resp_valid),
        .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_perms(ptw_resp_perms),
        .ptw_resp_fault(ptw_resp_fault),
        .st_rd_set_index(st_rd_set_index), .st_rd_valid(st_rd_valid),
        .st_rd_vpn(st_rd_vpn), .st_rd_ppn(st_rd_ppn),
        .st_rd_perms(st_rd_perms), .st_rd_lru_count(st_rd_lru_count),
        .st_wr_en(st_wr_en), .st_update_en(st_update_en),
        .st_wr_set_index(st_wr_set_index), .st_wr_way(st_wr_way),
        .st_wr_valid(st_wr_valid), .st_wr_vpn(st_wr_vpn),
        .st_wr_ppn(st_wr_ppn), .st_wr_perms(st_wr_perms),
        .st_wr_lru_count(st_wr_lru_count),
        .st_lru_update_en(st_lru_update_en),
        .st_lru_set_index(st_lru_set_index), .st_lru_way(st_lru_way)
    );

    // Storage array fixture: applies the DUT's write strobes
    logic          store_clear;
    logic          s_valid [NS][NW];
    logic [19:0]   s_vpn   [NS][NW];
    logic [19:0]   s_ppn   [NS][NW];
    logic [1:0]    s_perms [NS][NW];
    logic [LB-1:0] s_lru   [NS][NW];

    always_comb begin
        st_rd_valid     = '0;
        st_rd_vpn       = '0;
        st_rd_ppn       = '0;
        st_rd_perms     = '0;
        st_rd_lru_count = '0;
        for (int w = 0; w < NW; w++) begin
            st_rd_valid[w]              = s_valid[st_rd_set_index][w];
            st_rd_vpn[w*20 +: 20]       = s_vpn[st_rd_set_index][w];
            st_rd_ppn[w*20 +: 20]       = s_ppn[st_rd_set_index][w];
            st_rd_perms[w*2 +: 2]       = s_perms[st_rd_set_index][w];
            st_rd_lru_count[w*LB +: LB] = s_lru[st_rd_set_index][w];
        end
    end

    always @(posedge clk) begin
        if (store_clear) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++) begin
                    s_valid[s][w] <= 1'b0;
                    s_vpn[s][w]   <= '0;
                    s_ppn[s][w]   <= '0;
                    s_perms[s][w] <= '0;
                    s_lru[s][w]   <= '0;
                end
        end else begin
            if (st_update_en) begin
                s_valid[st_wr_set_index][st_wr_way] <= st_wr_valid;
                s_vpn[st_wr_set_index][st_wr_way]   <= st_wr_vpn;
                s_ppn[st_wr_set_index][st_wr_way]   <= st_wr_ppn;
                s_perms[st_wr_set_index][st_wr_way] <= st_wr_perms;
                s_lru[st_wr_set_index][st_wr_way]   <= st_wr_lru_count;
            end
            if (st_lru_update_en)
                s_lru[st_lru_set_index][st_lru_way] <=
                    s_lru[st_lru_set_index][st_lru_way] + 1'b1;
        end
    end

    // Reference TLB contents and expectation queues
    typedef struct packed {
        logic [31:0] paddr;
        logic        hit;
        logic        fault;
    } resp_t;
    typedef struct packed {
        logic [3:0]  set;
        logic [1:0]  way;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic [1:0]  perms;
    } fill_t;
    typedef struct packed {
        logic [3:0] set;
        logic [1:0] way;
    } bump_t;

    bit          r_valid [NS][NW];
    logic [19:0] r_vpn   [NS][NW];
    logic [19:0] r_ppn   [NS][NW];
    logic [1:0]  r_perms [NS][NW];
    int          r_lru   [NS][NW];
    resp_t rq[$];
    fill_t fq[$];
    bump_t bq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [31:0] va, input logic wr,
                         input logic [19:0] wppn, input logic [1:0] wperms,
                         input logic wfault);
        logic [19:0] vpn;
        int s, h, v;
        logic ok;
        resp_t r;
        fill_t f;
        bump_t b;
        vpn = va[31:12];
        s = int'(vpn[3:0]);
        h = -1;
        v = -1;
        for (int w = 0; w < NW; w++)
            if (h < 0 && r_valid[s][w] && r_vpn[s][w] == vpn) h = w;
        if (h >= 0) begin
            ok = wr ? r_perms[s][h][1] : r_perms[s][h][0];
            r.hit = 1'b1;
            r.fault = !ok;
            r.paddr = ok ? {r_ppn[s][h], va[11:0]} : 32'h0;
            rq.push_back(r);
            if (r_lru[s][h] != 15) begin
                b.set = vpn[3:0];
                b.way = 2'(h);
                bq.push_back(b);
                r_lru[s][h]++;
            end
        end else begin
            for (int w = 0; w < NW; w++)
                if (v < 0 && !r_valid[s][w]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < NW; w++)
                    if (r_lru[s][w] < r_lru[s][v]) v = w;
            end
            if (wfault) begin
                r.paddr = 32'h0;
                r.hit = 1'b0;
                r.fault = 1'b1;
            end else begin
                f.set = vpn[3:0];
                f.way = 2'(v);
                f.vpn = vpn;
                f.ppn = wppn;
                f.perms = wperms;
                fq.push_back(f);
                r_valid[s][v] = 1'b1;
                r_vpn[s][v] = vpn;
                r_ppn[s][v] = wppn;
                r_perms[s][v] = wperms;
                r_lru[s][v] = 0;
                ok = wr ? wperms[1] : wperms[0];
                r.hit = 1'b0;
                r.fault = !ok;
                r.paddr = ok ? {wppn, va[11:0]} : 32'h0;
            end
            rq.push_back(r);
        end
    endtask

    // Per-cycle compare process, sampled mid-low-phase
    int          wr_pulses = 0;
    logic [31:0] last_paddr;
    logic        last_hit, last_fault;
    logic [1:0]  last_fill_way;

    initial begin
        resp_t pv;
        resp_t e;
        fill_t f;
        bump_t b;
        logic pv_rv, pv_rr, pv_pv, pv_pr, pv_rst;
        logic [19:0] pv_vpn;
        pv = '0;
        pv_rv = 0; pv_rr = 0; pv_pv = 0; pv_pr = 0; pv_rst = 1;
        pv_vpn = '0;
        forever begin
            @(negedge clk);
            #2;
            if (st_wr_en || st_update_en || st_lru_update_en) begin
                chk("strobe_excl", st_update_en & st_lru_update_en, 0);
                chk("wr_en_or", st_wr_en, st_update_en | st_lru_update_en);
            end
            if (st_update_en) begin
                wr_pulses++;
                last_fill_way = st_wr_way;
                if (fq.size() == 0) begin
                    chk("fill_unexpected", st_update_en, 0);
                end else begin
                    f = fq.pop_front();
                    chk("fill_set", st_wr_set_index, f.set);
                    chk("fill_way", st_wr_way, f.way);
                    chk("fill_vpn", st_wr_vpn, f.vpn);
                    chk("fill_ppn", st_wr_ppn, f.ppn);
                    chk("fill_perms", st_wr_perms, f.perms);
                    chk("fill_valid", st_wr_valid, 1);
                    chk("fill_lru", st_wr_lru_count, 0);
                end
            end
            if (st_lru_update_en) begin
                wr_pulses++;
                if (bq.size() == 0) begin
                    chk("bump_unexpected", st_lru_update_en, 0);
                end else begin
                    b = bq.pop_front();
                    chk("bump_set", st_lru_set_index, b.set);
                    chk("bump_way", st_lru_way, b.way);
                end
            end
            if (pv_rv && !pv_rr && !pv_rst) begin
                chk("resp_hold_valid", resp_valid, 1);
                chk("resp_hold_paddr", resp_paddr, pv.paddr);
                chk("resp_hold_flags", {resp_hit, resp_fault},
                    {pv.hit, pv.fault});
            end
            if (pv_pv && !pv_pr && !pv_rst) begin
                chk("ptw_hold_valid", ptw_req_valid, 1);
                chk("ptw_hold_vpn", ptw_vpn, pv_vpn);
            end
            if (resp_valid && resp_ready) begin
                last_paddr = resp_paddr;
                last_hit = resp_hit;
                last_fault = resp_fault;
                if (rq.size() == 0) begin
                    chk("resp_unexpected", resp_valid, 0);
                end else begin
                    e = rq.pop_front();
                    chk("resp_paddr", resp_paddr, e.paddr);
                    chk("resp_hit", resp_hit, e.hit);
                    chk("resp_fault", resp_fault, e.fault);
                end
            end
            pv = '{resp_paddr, resp_hit, resp_fault};
            pv_rv = resp_valid;
            pv_rr = resp_ready;
            pv_pv = ptw_req_valid;
            pv_pr = ptw_req_ready;
            pv_vpn = ptw_vpn;
            pv_rst = rst;
        end
    end

    // One full transaction with a scripted walker and requester
    task automatic do_req(input logic [31:0] va, input logic wr,
                          input logic [19:0] wppn, input logic [1:0] wperms,
                          input logic wfault, input int ptw_stall,
                          input int rsp_stall, output int rc, output int pc);
        int cyc, pw, rw;
        bit pend, done;
        cyc = 0; pw = 0; rw = 0; pend = 0; done = 0;
        rc = -1;
        pc = -1;
        model(va, wr, wppn, wperms, wfault);
        @(negedge clk);
        wr_pulses = 0;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_vaddr = va;
        req_is_write = wr;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            ptw_resp_valid = 1'b0;
            ptw_req_ready = 1'b0;
            resp_ready = 1'b0;
            if (pend) begin
                ptw_resp_valid = 1'b1;
                ptw_resp_ppn = wppn;
                ptw_resp_perms = wperms;
                ptw_resp_fault = wfault;
                pend = 0;
            end else if (ptw_req_valid) begin
                if (pc < 0) pc = cyc;
                if (pw >= ptw_stall) begin
                    ptw_req_ready = 1'b1;
                    pend = 1;
                end
                pw++;
            end
            if (resp_valid) begin
                if (rc < 0) rc = cyc;
                if (rw >= rsp_stall) begin
                    resp_ready = 1'b1;
                    done = 1;
                end
                rw++;
            end
        end
        chk("req_timeout", done, 1);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        ptw_req_ready = 1'b0;
        ptw_resp_valid = 1'b0;
    endtask

    initial begin
        int rc, pc;
        bit seen;
        rst = 1'b1;
        store_clear = 1'b1;
        req_valid = 0; req_vaddr = 0; req_is_write = 0;
        resp_ready = 0; ptw_req_ready = 0; ptw_resp_valid = 0;
        ptw_resp_ppn = 0; ptw_resp_perms = 0; ptw_resp_fault = 0;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                r_valid[s][w] = 0;
                r_vpn[s][w] = '0;
                r_ppn[s][w] = '0;
                r_perms[s][w] = '0;
                r_lru[s][w] = 0;
            end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        store_clear = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ptw_valid", ptw_req_valid, 0);
        chk("rst_strobes", {st_wr_en, st_update_en, st_lru_update_en}, 0);
        chk("rst_paddr", resp_paddr, 0);
        chk("rst_set_index", st_rd_set_index, 0);

        // Cold miss, then a hit on the same address
        do_req(32'h0001_2345, 0, 20'hABCDE, 2'b11, 0, 0, 0, rc, pc);
        chk("t1_paddr", last_paddr, 32'hABCD_E345);
        chk("t1_hit", last_hit, 0);
        chk("t1_ptw_cycle", pc, 2);
        chk("t1_resp_cycle", rc, 5);
        chk("t1_fill_way", last_fill_way, 0);
        chk("t1_writes", wr_pulses, 1);
        do_req(32'h0001_2345, 0, 20'h0, 2'b00, 0, 0, 0, rc, pc);
        chk("t2_hit", last_hit, 1);
        chk("t2_paddr", last_paddr, 32'hABCD_E345);
        chk("t2_resp_cycle", rc, 2);
        chk("t2_writes", wr_pulses, 1);

        // Fill set 2 and shape counters to {3,1,1,2}
        do_req(32'h0002_2100, 0, 20'h22222, 2'b11, 0, 0, 0, rc, pc);
        do_req(32'h0003_2100, 0, 20'h33333, 2'b11, 0, 0, 0, rc, pc);
        do_req(32'h0004_2100, 0, 20'h44444, 2'b11, 0, 0, 0, rc, pc);
        chk("fill4_way", last_fill_way, 3);
        repeat (2) do_req(32'h0001_2000, 0, 0, 0, 0, 0, 0, rc, pc);
        do_req(32'h0002_2004, 0, 0, 0, 0, 0, 0, rc, pc);
        do_req(32'h0003_2008, 1, 0, 0, 0, 0, 0, rc, pc);
        repeat (2) do_req(32'h0004_200C, 0, 0, 0, 0, 0, 0, rc, pc);
        chk("bump_hit_paddr", last_paddr, 32'h4444_400C);
        do_req(32'h0005_2ABC, 0, 20'h55555, 2'b11, 0, 0, 0, rc, pc);
        chk("victim_way", last_fill_way, 1);
        do_req(32'h0005_2ABC, 0, 0, 0, 0, 0, 0, rc, pc);
        chk("victim_new_hit", last_hit, 1);
        do_req(32'h0002_2100, 0, 20'h22223, 2'b11, 0, 0, 0, rc, pc);
        chk("victim_old_miss", last_hit, 0);

        // Read-only entry, saturate its counter, then a write faults
        do_req(32'h0001_3ABC, 0, 20'h13131, 2'b01, 0, 0, 0, rc, pc);
        repeat (16) do_req(32'h0001_3ABC, 0, 0, 0, 0, 0, 0, rc, pc);
        chk("sat_writes", wr_pulses, 0);
        do_req(32'h0001_3ABC, 1, 0, 0, 0, 0, 0, rc, pc);
        chk("perm_fault", last_fault, 1);
        chk("perm_paddr", last_paddr, 0);
        chk("perm_hit", last_hit, 1);
        chk("perm_writes", wr_pulses, 0);

        // Write miss filled with read-only perms still faults
        do_req(32'h0002_4010, 1, 20'h24242, 2'b01, 0, 0, 0, rc, pc);
        chk("fillperm_fault", last_fault, 1);
        chk("fillperm_writes", wr_pulses, 1);

        // Walker fault: no fill
        do_req(32'h0007_7777, 0, 20'h77777, 2'b11, 1, 0, 0, rc, pc);
        chk("walkfault_fault", last_fault, 1);
        chk("walkfault_hit", last_hit, 0);
        chk("walkfault_writes", wr_pulses, 0);

        // Back-pressure on walker request and response
        do_req(32'h0003_5555, 0, 20'h35353, 2'b11, 0, 5, 3, rc, pc);
        chk("stall_ptw_cycle", pc, 2);
        chk("stall_resp_cycle", rc, 10);
        chk("stall_paddr", last_paddr, 32'h3535_3555);

        // Reset while waiting on the walker
        @(negedge clk);
        wr_pulses = 0;
        req_valid = 1'b1;
        req_vaddr = 32'h0009_9123;
        req_is_write = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ptw_req_valid) seen = 1;
        end
        chk("rst_walk_seen", seen, 1);
        ptw_req_ready = 1'b1;
        @(posedge clk);
        #1 ptw_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_ptw_valid", ptw_req_valid, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        @(negedge clk);
        ptw_resp_valid = 1'b1;
        ptw_resp_ppn = 20'h99999;
        ptw_resp_perms = 2'b11;
        ptw_resp_fault = 1'b0;
        @(negedge clk);
        ptw_resp_valid = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        chk("midrst_no_fill", wr_pulses, 0);
        do_req(32'h0009_9123, 0, 20'h99998, 2'b11, 0, 0, 0, rc, pc);
        chk("midrst_then_miss", last_hit, 0);
        chk("midrst_paddr", last_paddr, 32'h9999_8123);

        repeat (3) @(negedge clk);
        chk("leftover_resp", rq.size(), 0);
        chk("leftover_fill", fq.size(), 0);
        chk("leftover_bump", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
